mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: a CPU that owns the bus by default and a DMA
// requester that is granted bounded bursts in between CPU read cycles.
// Memory-side signals are a pure mux of the current owner; DMA read data
// is flagged by a tag pipeline matched to the memory read latency.
module mem_arbiter #(
  parameter int MAX_DMA_BURST  = 8,
  parameter int MIN_CPU_CYCLES = 1,
  parameter int READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address_out,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_READ_write,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_rdy,
  input  logic        dma_req,
  input  logic [15:0] dma_address,
  input  logic [7:0]  dma_data_out,
  input  logic        dma_READ_write,
  output logic        dma_grant,
  output logic [7:0]  dma_data_in,
  output logic        dma_rvalid,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data_in,
  output logic        mem_READ_write,
  input  logic [7:0]  mem_data_out
);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_t;

  localparam logic [7:0] MIN_CPU   = 8'(MIN_CPU_CYCLES);
  localparam logic [7:0] MAX_BURST = 8'(MAX_DMA_BURST);

  state_t                  state;
  logic [7:0]              cpu_cnt;
  logic [7:0]              dma_cnt;
  logic [7:0]              cpu_cnt_inc;
  logic [7:0]              dma_cnt_inc;
  logic                    grant_ok;
  logic                    burst_done;
  logic                    dma_rd_issue;
  logic [READ_LATENCY-1:0] tag_pipe;

  // cpu_cnt_inc is the number of CPU cycles owned including the current one,
  // so MIN_CPU_CYCLES=1 lets the DMA back in after a single CPU cycle.
  assign cpu_cnt_inc  = (cpu_cnt == 8'hFF) ? 8'hFF : cpu_cnt + 8'd1;
  assign dma_cnt_inc  = dma_cnt + 8'd1;
  assign grant_ok     = dma_req & cpu_READ_write & (cpu_cnt_inc >= MIN_CPU);
  assign burst_done   = dma_req & (dma_cnt_inc >= MAX_BURST);
  assign dma_rd_issue = (state == S_DMA) & dma_req & dma_READ_write;

  // Ownership FSM with its cycle counters and registered ownership flags;
  // a CPU write is never preempted because grant_ok requires a CPU read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_CPU;
      cpu_cnt   <= MIN_CPU;
      dma_cnt   <= 8'd0;
      cpu_rdy   <= 1'b1;
      dma_grant <= 1'b0;
    end else begin
      case (state)
        S_CPU: begin
          cpu_cnt <= cpu_cnt_inc;
          if (grant_ok) begin
            state     <= S_DMA;
            dma_cnt   <= 8'd0;
            cpu_rdy   <= 1'b0;
            dma_grant <= 1'b1;
          end
        end
        S_DMA: begin
          if (dma_req) begin
            dma_cnt <= dma_cnt_inc;
          end
          if (!dma_req || burst_done) begin
            state     <= S_CPU;
            cpu_cnt   <= 8'd0;
            cpu_rdy   <= 1'b1;
            dma_grant <= 1'b0;
          end
        end
        default: begin
          state     <= S_CPU;
          cpu_cnt   <= 8'd0;
          cpu_rdy   <= 1'b1;
          dma_grant <= 1'b0;
        end
      endcase
    end
  end

  // Owner tag pipeline: one bit per DMA read issue, aged one stage per clock,
  // independent of later ownership changes so in-flight reads still complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= dma_rd_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign dma_rvalid = tag_pipe[READ_LATENCY-1];

  // Memory-side mux of the owning master; an idle DMA slot is forced to a read
  // so a stale DMA write request can never reach memory.
  always_comb begin
    mem_address    = cpu_address_out;
    mem_data_in    = cpu_data_out;
    mem_READ_write = cpu_READ_write;
    if (state == S_DMA) begin
      mem_address    = dma_address;
      mem_data_in    = dma_data_out;
      mem_READ_write = dma_req ? dma_READ_write : 1'b1;
    end
  end

  assign cpu_data_in = mem_data_out;
  assign dma_data_in = mem_data_out;

endmodule
